rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Parametrised N-way arbiter; successor to the combinational priority encoder and one-hot decoder support blocks.
- Adds registered round-robin fairness, a runtime fixed-priority fallback mode, and a valid/ready grant handshake.
- Adds a lock mechanism so multi-beat transfers keep one requester granted.
- Sits in front of shared NPU resources (SRAM banks, bus ports), under design_rtl/support.

Parameters:
N, 4, number of requesters; legal range 2..64.
IDX_W, $clog2(N), width of the encoded grant index; derived, not overridden.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
req  input  N  request vector; bit i = requester i.
rr_en  input  1  1 = round-robin, 0 = fixed priority (lowest index wins).
lock  input  1  sampled only on an accepting cycle; requests that the current holder keeps the grant.
gnt_valid  output  1  a grant is presented.
gnt_ready  input  1  consumer accepts the presented grant.
gnt_onehot  output  N  one-hot grant; all zero when gnt_valid=0.
gnt_idx  output  IDX_W  encoded grant index; 0 when gnt_valid=0.

Behaviour:
- Reset (rst_n=0 at a clk edge): gnt_valid=0, gnt_onehot=0, gnt_idx=0, internal pointer ptr=0. Reset mid-grant drops the grant the next edge; no accept is recorded.
- All outputs are registered. Latency is 1 cycle from req to gnt_valid.
- gnt_onehot is always the decode of gnt_idx when valid; exactly one bit is set.
- States (implicit in gnt_valid):
  - IDLE (gnt_valid=0): each edge arbitrates req.
    - Any bit set -> GRANT with the winner.
    - Otherwise stay IDLE.
  - GRANT, gnt_ready=0: outputs hold stable, even if req changes or req[gnt_idx] drops. Requesters must hold req until accepted.
  - GRANT, gnt_ready=1 (accept):
    - If lock=1 and req[gnt_idx]=1: re-grant the same index next cycle; ptr unchanged.
    - Otherwise: ptr <= (gnt_idx+1) mod N, wrapping N-1 -> 0. Arbitrate req this cycle and load the result.
    - Empty req -> IDLE.
- No bubble between back-to-back accepts while requests remain.
- Arbitration, round-robin (rr_en=1): the first set bit scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1. The search on accept uses the updated ptr value.
- Arbitration, fixed priority (rr_en=0): lowest set index. ptr still updates on accept and is not used.
- rr_en may change on any cycle. It affects only arbitrations performed at that edge.
- The request of the just-accepted requester takes part in the new arbitration. It is lowest priority in round-robin mode; under lock it is re-granted.
- lock while gnt_valid=0 or gnt_ready=0 is ignored.
- Starvation: in RR mode, a continuously asserted request is granted within N accepts, lock excluded.

Test Plan:
- Reset, then N=4, req=0000 for 5 cycles -> gnt_valid=0, gnt_onehot=0, gnt_idx=0 throughout.
- RR rotation: rr_en=1, req=1111 held, gnt_ready=1 -> gnt_idx sequence 0,1,2,3,0,1 on consecutive cycles, no bubbles. First grant appears 1 cycle after req.
- Backpressure: req=0110, gnt_ready=0 for 4 cycles -> gnt_idx=1 held stable, even when req changes to 0100 mid-hold. gnt_ready=1 -> next grant idx=2.
- Fixed mode: rr_en=0, req=1010 held, ready=1 -> gnt_idx=1 every cycle. Switch to rr_en=1 -> next grant idx=3, then 1.
- Lock: req=1001, grant idx=0 accepted with lock=1 for 3 beats -> idx=0 for 4 consecutive grants. lock=0 on the next accept -> idx=3.
- Wrap and reset: grant idx=3 accepted (ptr->0), req=1001 -> idx=0. Assert rst_n=0 while gnt_valid=1 -> outputs 0 next edge. After release with req=1000 -> idx=3 (ptr reset to 0).

Source files
------------

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   N-way request arbiter. It offers round-robin or fixed-priority selection,
//   presents the grant through a valid/ready handshake, and can lock a grant
//   across multi-beat transfers.
//
// Handshake: a grant is presented while gnt_valid=1. It is accepted on a
//   rising edge where gnt_valid=1 and gnt_ready=1. Until it is accepted,
//   gnt_valid, gnt_idx and gnt_onehot hold stable whatever req does.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   req[N]      request vector, bit i = requester i
//   rr_en       1 = round-robin from ptr, 0 = lowest index wins
//   lock        on an accept, keep the current holder if it still requests
//   gnt_valid   grant presented; this is also the IDLE/GRANT state
//   gnt_ready   consumer accepts the presented grant
//   gnt_onehot  one-hot grant, zero when idle
//   gnt_idx     encoded grant index, zero when idle
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter  int N     = 4,
   localparam int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     req,
   input  logic             rr_en,
   input  logic             lock,
   output logic             gnt_valid,
   input  logic             gnt_ready,
   output logic [N-1:0]     gnt_onehot,
   output logic [IDX_W-1:0] gnt_idx
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
   localparam logic [N-1:0]     ONE  = {{(N-1){1'b0}}, 1'b1};

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] next_ptr;
   logic [IDX_W-1:0] base;
   logic [IDX_W-1:0] win_idx;
   logic             win_found;
   logic             accept;
   logic             keep;

   // Circular scan of r starting at b. Returns {found, index}.
   function automatic logic [IDX_W:0] arbitrate(input logic [N-1:0]     r,
                                                 input logic [IDX_W-1:0] b);
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] pos;
      int               j;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(b) + k;
         if (j >= N) j = j - N;
         pos = IDX_W'(j);
         if (!found && r[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      accept   = gnt_valid & gnt_ready;
      keep     = accept & lock & req[gnt_idx];
      next_ptr = ptr;
      // The just-accepted requester moves to the back of the rotation.
      if (accept && !keep)
         next_ptr = (gnt_idx == LAST) ? '0 : gnt_idx + IDX_W'(1);
      // Fixed priority is a scan that always starts at index 0.
      base = rr_en ? next_ptr : '0;
      {win_found, win_idx} = arbitrate(req, base);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr        <= '0;
         gnt_valid  <= 1'b0;
         gnt_idx    <= '0;
         gnt_onehot <= '0;
      end else if (!gnt_valid || gnt_ready) begin
         // A locked accept leaves ptr and every output unchanged, which is
         // exactly a re-grant of the same index.
         if (!keep) begin
            ptr        <= next_ptr;
            gnt_valid  <= win_found;
            gnt_idx    <= win_found ? win_idx : '0;
            gnt_onehot <= win_found ? (ONE << win_idx) : '0;
         end
      end
   end

endmodule

// File: tb/tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter
//   Directed checks from the test plan, followed by randomized traffic. Every
//   cycle is compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_rr_arbiter;

   localparam int N     = 4;
   localparam int IDX_W = $clog2(N);

   logic             clk;
   logic             rst_n;
   logic [N-1:0]     req;
   logic             rr_en;
   logic             lock;
   logic             gnt_ready;
   logic             gnt_valid;
   logic [N-1:0]     gnt_onehot;
   logic [IDX_W-1:0] gnt_idx;

   int n_cmp;
   int n_err;

   // reference model state
   bit m_valid;
   int m_idx;
   int m_ptr;

   rr_arbiter #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .rr_en      (rr_en),
      .lock       (lock),
      .gnt_valid  (gnt_valid),
      .gnt_ready  (gnt_ready),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Evaluated once per rising edge with the inputs the DUT sees at that edge.
   task automatic model_edge();
      int cand;
      if (!rst_n) begin
         m_valid = 0;
         m_idx   = 0;
         m_ptr   = 0;
      end else if (!m_valid || gnt_ready) begin
         if (m_valid && gnt_ready && lock && req[m_idx]) begin
            // locked re-grant: nothing changes
         end else begin
            if (m_valid) m_ptr = (m_idx + 1) % N;
            m_valid = 0;
            m_idx   = 0;
            for (int k = 0; k < N; k++) begin
               cand = rr_en ? (m_ptr + k) % N : k;
               if (!m_valid && req[cand]) begin
                  m_valid = 1;
                  m_idx   = cand;
               end
            end
         end
      end
   endtask

   // ---------------- checks ----------------
   task automatic check_model(input string tag);
      logic [N-1:0] exp_oh;
      exp_oh = m_valid ? (N'(1) << m_idx) : '0;
      n_cmp++;
      assert (gnt_valid === m_valid)
      else begin
         n_err++;
         $error("FAIL %s valid: got %0b want %0b", tag, gnt_valid, m_valid);
      end
      n_cmp++;
      assert (gnt_idx === IDX_W'(m_idx))
      else begin
         n_err++;
         $error("FAIL %s idx: got %0d want %0d", tag, gnt_idx, m_idx);
      end
      n_cmp++;
      assert (gnt_onehot === exp_oh)
      else begin
         n_err++;
         $error("FAIL %s onehot: got %b want %b", tag, gnt_onehot, exp_oh);
      end
   endtask

   // Plan-level constant check, independent of the model.
   task automatic check_const(input string tag, input bit exp_v, input int exp_i);
      n_cmp++;
      assert (gnt_valid === exp_v && gnt_idx === IDX_W'(exp_i))
      else begin
         n_err++;
         $error("FAIL %s: got valid=%0b idx=%0d want valid=%0b idx=%0d",
                tag, gnt_valid, gnt_idx, exp_v, exp_i);
      end
   endtask

   // ---------------- driver ----------------
   task automatic tick(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check_model(tag);
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req       = '0;
      lock      = 1'b0;
      gnt_ready = 1'b0;
      rr_en     = 1'b1;
      tick("reset");
      tick("reset");
      rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_cmp   = 0;
      n_err   = 0;
      m_valid = 0;
      m_idx   = 0;
      m_ptr   = 0;

      // reset, then idle with no requests
      do_reset();
      check_const("reset_state", 0, 0);
      for (int i = 0; i < 5; i++) begin
         tick("idle");
         check_const("idle_no_req", 0, 0);
      end

      // round-robin rotation with no bubbles
      do_reset();
      req = 4'b1111; gnt_ready = 1'b1; rr_en = 1'b1;
      begin
         int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
         for (int i = 0; i < 6; i++) begin
            tick("rr_rot");
            check_const("rr_rotation", 1, exp_seq[i]);
         end
      end
      req = '0;
      tick("rr_drain");
      check_const("rr_to_idle", 0, 0);

      // backpressure: grant holds while ready is low
      do_reset();
      req = 4'b0110; gnt_ready = 1'b0;
      tick("bp_first");
      check_const("bp_first", 1, 1);
      for (int i = 0; i < 4; i++) begin
         if (i == 2) req = 4'b0100;
         tick("bp_hold");
         check_const("bp_hold", 1, 1);
      end
      gnt_ready = 1'b1;
      tick("bp_accept");
      check_const("bp_next", 1, 2);

      // fixed priority, then switch to round-robin
      do_reset();
      rr_en = 1'b0; req = 4'b1010; gnt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick("fixed");
         check_const("fixed_prio", 1, 1);
      end
      rr_en = 1'b1;
      tick("fix2rr_a");
      check_const("fix2rr_first", 1, 3);
      tick("fix2rr_b");
      check_const("fix2rr_second", 1, 1);

      // lock holds the grant for multi-beat transfers
      do_reset();
      rr_en = 1'b1; req = 4'b1001; gnt_ready = 1'b1; lock = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick("lock");
         check_const("lock_hold", 1, 0);
      end
      lock = 1'b0;
      tick("unlock");
      check_const("unlock_next", 1, 3);

      // wrap of ptr, then reset in the middle of a grant
      tick("wrap");
      check_const("wrap_to_0", 1, 0);
      rst_n = 1'b0;
      tick("mid_reset");
      check_const("mid_reset", 0, 0);
      rst_n = 1'b1; req = 4'b1000; gnt_ready = 1'b0;
      tick("post_reset");
      check_const("post_reset", 1, 3);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         req       = N'($urandom);
         if ($urandom_range(0, 3) == 0) req = '0;
         rr_en     = ($urandom_range(0, 4) != 0);
         lock      = ($urandom_range(0, 2) == 0);
         gnt_ready = ($urandom_range(0, 2) != 0);
         tick("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
